// File: rtl/bayer_pattern_gen.sv
// ---------------------------------------------------------------------------
// bayer_pattern_gen
//   Synthetic camera source producing a raw Bayer stream (even rows G,R,...;
//   odd rows B,G,...) with horizontal and vertical blanking. It stands in for
//   the CCD capture block so downstream results are deterministic.
//
// Ports
//   iCLK         clock
//   iRST         asynchronous active-low reset
//   iSTART       one-cycle pulse, starts a frame when idle
//   iCONT        1 = run frames back-to-back
//   iEN          clock enable; 0 freezes the generator
//   iMODE[1:0]   pattern: 0 flat, 1 ramp, 2 colour bars, 3 checker
//   iLEVEL[11:0] flat-mode sample value
//   oDATA[11:0]  Bayer sample
//   oX_Cont      column of the current sample
//   oY_Cont      row of the current sample
//   oDVAL        sample valid
//   oBUSY        generator not idle
//   oFrame_Cont  completed-frame count (wraps)
// ---------------------------------------------------------------------------
module bayer_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 960,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 8,
    parameter int BAR_W    = 160
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iCONT,
    input  logic        iEN,
    input  logic [1:0]  iMODE,
    input  logic [11:0] iLEVEL,
    output logic [11:0] oDATA,
    output logic [10:0] oX_Cont,
    output logic [10:0] oY_Cont,
    output logic        oDVAL,
    output logic        oBUSY,
    output logic [15:0] oFrame_Cont
);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

    localparam int VB_CYC = V_BLANK * (H_ACTIVE + H_BLANK);
    localparam int HBW    = $clog2(H_BLANK + 1);
    localparam int VBW    = $clog2(VB_CYC + 1);
    localparam int BCW    = $clog2(BAR_W + 1);

    state_t          state_q;
    logic [10:0]     x_q, y_q;
    logic [HBW-1:0]  hcnt_q;
    logic [VBW-1:0]  vcnt_q;
    logic [BCW-1:0]  bar_cnt_q;
    logic [2:0]      bar_idx_q;
    logic [1:0]      mode_q;
    logic [11:0]     level_q;
    logic [11:0]     data_q;
    logic [10:0]     ox_q, oy_q;
    logic            dval_q, busy_q;
    logic [15:0]     frame_q;

    // Pattern value for the pixel at (x_q, y_q)
    logic        ch_r, ch_g, ch_b, bar_on;
    logic [11:0] sample_d;

    always_comb begin
        ch_r     = ~y_q[0] &  x_q[0];
        ch_b     =  y_q[0] & ~x_q[0];
        ch_g     = ~(y_q[0] ^ x_q[0]);
        // Bar index bits gate R, G, B respectively: bar 0 white, bar 7 black
        bar_on   = (ch_r & ~bar_idx_q[2]) | (ch_g & ~bar_idx_q[1]) | (ch_b & ~bar_idx_q[0]);
        sample_d = 12'h000;
        case (mode_q)
            2'd0:    sample_d = level_q;
            2'd1:    sample_d = {x_q, 1'b0};
            2'd2:    sample_d = bar_on ? 12'hFFF : 12'h000;
            default: sample_d = (x_q[4] ^ y_q[4]) ? 12'hFFF : 12'h000;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            mode_q    <= '0;
            level_q   <= '0;
            data_q    <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            dval_q    <= 1'b0;
            busy_q    <= 1'b0;
            frame_q   <= '0;
        end else if (!iEN) begin
            // Stall: everything holds, only the valid strobe drops
            dval_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    dval_q <= 1'b0;
                    data_q <= 12'h000;
                    if (iSTART) begin
                        mode_q    <= iMODE;
                        level_q   <= iLEVEL;
                        x_q       <= '0;
                        y_q       <= '0;
                        bar_cnt_q <= '0;
                        bar_idx_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_ACTIVE;
                    end
                end

                S_ACTIVE: begin
                    data_q <= sample_d;
                    ox_q   <= x_q;
                    oy_q   <= y_q;
                    dval_q <= 1'b1;
                    // Bar tracking by sub-counter; index saturates at 7
                    if (bar_cnt_q == BCW'(BAR_W - 1)) begin
                        bar_cnt_q <= '0;
                        if (bar_idx_q != 3'd7)
                            bar_idx_q <= bar_idx_q + 3'd1;
                    end else begin
                        bar_cnt_q <= bar_cnt_q + BCW'(1);
                    end
                    if (x_q == 11'(H_ACTIVE - 1)) begin
                        x_q       <= '0;
                        bar_cnt_q <= '0;
                        bar_idx_q <= '0;
                        hcnt_q    <= '0;
                        state_q   <= S_HBLANK;
                    end else begin
                        x_q <= x_q + 11'd1;
                    end
                end

                S_HBLANK: begin
                    dval_q <= 1'b0;
                    data_q <= 12'h000;
                    if (hcnt_q == HBW'(H_BLANK - 1)) begin
                        hcnt_q <= '0;
                        if (y_q == 11'(V_ACTIVE - 1)) begin
                            vcnt_q  <= '0;
                            state_q <= S_VBLANK;
                        end else begin
                            y_q     <= y_q + 11'd1;
                            state_q <= S_ACTIVE;
                        end
                    end else begin
                        hcnt_q <= hcnt_q + HBW'(1);
                    end
                end

                default: begin // S_VBLANK
                    dval_q <= 1'b0;
                    data_q <= 12'h000;
                    if (vcnt_q == VBW'(VB_CYC - 1)) begin
                        vcnt_q  <= '0;
                        frame_q <= frame_q + 16'd1;
                        x_q     <= '0;
                        y_q     <= '0;
                        if (iCONT) begin
                            // Back-to-back frame: re-latch pattern settings
                            mode_q  <= iMODE;
                            level_q <= iLEVEL;
                            state_q <= S_ACTIVE;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        vcnt_q <= vcnt_q + VBW'(1);
                    end
                end
            endcase
        end
    end

    assign oDATA       = data_q;
    assign oX_Cont     = ox_q;
    assign oY_Cont     = oy_q;
    assign oDVAL       = dval_q;
    assign oBUSY       = busy_q;
    assign oFrame_Cont = frame_q;

endmodule
